// File: rtl/param_bram_pkg.sv
// param_bram_pkg: shared types for the param_bram scratch memory.
// FSM state enum, INIT_MODE encodings and the init_pattern() helper.
package param_bram_pkg;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  localparam logic [1:0] INIT_ZERO = 2'd0;
  localparam logic [1:0] INIT_DESC = 2'd1;
  localparam logic [1:0] INIT_ASC  = 2'd2;

  // Result is wide; callers truncate to the data width,
  // which yields the modulo 2**DATA_W wrap for free.
  function automatic logic [31:0] init_pattern(
    input logic [31:0] index,
    input logic [1:0]  mode,
    input logic [31:0] depth
  );
    logic [31:0] r;
    r = '0;
    unique case (mode)
      INIT_DESC: r = depth - 32'd1 - index;
      INIT_ASC:  r = index;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_bram_array.sv
// param_bram_array: bare single-port synchronous RAM, registered read.
// Ports: clk, we_i, addr_i, wdata_i, rdata_o. No reset, infers BRAM.
module param_bram_array #(
  parameter int W  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [2**AW];

  // Read-before-write on a same-address collision; the
  // controller never issues a read and a write together.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/param_bram.sv
// param_bram: parametrised BRAM, valid/ready requests, hardware init sweep.
// Ports: clk, reset (async low), clear, req_valid/ready/we/addr/wdata,
// rsp_valid, rd_data, init_done; parity_err with PARAM_BRAM_PARITY_EN.
module param_bram
  import param_bram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int INIT_MODE = 1,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rd_data,
`ifdef PARAM_BRAM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              init_done
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef PARAM_BRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [1:0] MODE = 2'(INIT_MODE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              sweep;
  logic              accept;
  logic              rd_acc;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdat_c;
  logic [MEM_W-1:0]  arr_wdata;
  logic [MEM_W-1:0]  arr_rdata;
  logic              v1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = READY;
      end
      READY: state_d = READY;
      default: state_d = INIT;
    endcase
    if (clear) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  assign sweep     = (state_q == INIT);
  assign req_ready = (state_q == READY);
  assign init_done = (state_q == READY);

  // clear beats a simultaneous request.
  assign accept = req_valid & req_ready & ~clear;
  assign rd_acc = accept & ~req_we;

  // Gating with reset keeps the array untouched while held.
  assign arr_we = reset & ~clear
                & (sweep | (accept & req_we));

  assign arr_addr = sweep ? cnt_q : req_addr;

  assign wdata_c = sweep
    ? DATA_W'(init_pattern(32'(cnt_q), MODE, 32'(DEPTH)))
    : req_wdata;

`ifdef PARAM_BRAM_PARITY_EN
  logic perr_c;
  assign arr_wdata = {^wdata_c, wdata_c};
  assign perr_c    = ^arr_rdata;
`else
  assign arr_wdata = wdata_c;
`endif

  assign rdat_c = arr_rdata[DATA_W-1:0];

  param_bram_array #(
    .W  (MEM_W),
    .AW (ADDR_W)
  ) u_arr (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // v1_q marks the cycle the array output holds read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v1_q <= 1'b0;
    else        v1_q <= rd_acc;
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d2_q;
    logic              v2_q;
    logic              adv;

    assign adv = v1_q & ~clear;

    // d2_q only loads when a response is issued, so it
    // doubles as the hold register between responses.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= adv;
        if (adv) d2_q <= rdat_c;
      end
    end

    assign rsp_valid = v2_q;
    assign rd_data   = d2_q;

`ifdef PARAM_BRAM_PARITY_EN
    logic pe2_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) pe2_q <= 1'b0;
      else        pe2_q <= adv & perr_c;
    end
    assign parity_err = pe2_q;
`endif
  end else begin : g_lat1
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)    hold_q <= '0;
      else if (v1_q) hold_q <= rdat_c;
    end

    assign rsp_valid = v1_q;
    assign rd_data   = v1_q ? rdat_c : hold_q;

`ifdef PARAM_BRAM_PARITY_EN
    assign parity_err = v1_q & perr_c;
`endif
  end

endmodule

// File: tb/tb_param_bram.sv
// tb_param_bram: randomized and directed checks of param_bram.
// Three instances: defaults, READ_LAT=2, and DATA_W=4/ADDR_W=6/ascending.
module tb_param_bram;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;

  logic       rdy0, rv0, id0;
  logic [7:0] rd0;
  logic       rdy1, rv1, id1;
  logic [7:0] rd1;
  logic       rdy2, rv2, id2;
  logic [3:0] rd2;
`ifdef PARAM_BRAM_PARITY_EN
  logic       pe0, pe1, pe2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mem0 [256];
  logic [3:0] mem2 [64];
  logic [7:0] h0, h1;
  logic [3:0] h2;

  always #5 clk = ~clk;

  param_bram u0 (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (rdy0),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rv0),
    .rd_data    (rd0),
`ifdef PARAM_BRAM_PARITY_EN
    .parity_err (pe0),
`endif
    .init_done  (id0)
  );

  param_bram #(.READ_LAT(2)) u1 (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (rdy1),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rv1),
    .rd_data    (rd1),
`ifdef PARAM_BRAM_PARITY_EN
    .parity_err (pe1),
`endif
    .init_done  (id1)
  );

  param_bram #(
    .DATA_W    (4),
    .ADDR_W    (6),
    .INIT_MODE (2)
  ) u2 (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (rdy2),
    .req_we     (req_we),
    .req_addr   (req_addr[5:0]),
    .req_wdata  (req_wdata[3:0]),
    .rsp_valid  (rv2),
    .rd_data    (rd2),
`ifdef PARAM_BRAM_PARITY_EN
    .parity_err (pe2),
`endif
    .init_done  (id2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Expected contents after a completed sweep.
  task automatic init_model();
    for (int i = 0; i < 256; i++) mem0[i] = 8'(255 - i);
    for (int i = 0; i < 64; i++)  mem2[i] = 4'(i);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy0 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, n2;
    logic idlate;
    reset = 1'b0;
    clear = 1'b0;
    drive(0, 0, 8'h00, 8'h00);
    repeat (3) tick();
    checks++;
    if ({rdy0, rv0, id0, rd0} !== 11'd0) begin
      errors++;
      $display("FAIL rst_u0 got=%0h exp=0", {rdy0, rv0, id0, rd0});
    end
    checks++;
    if ({rdy1, rv1, id1, rd1, rv2, rd2} !== 16'd0) begin
      errors++;
      $display("FAIL rst_u1u2 got=%0h exp=0",
               {rdy1, rv1, id1, rd1, rv2, rd2});
    end
    reset = 1'b1;
    n = 0;
    n2 = 0;
    idlate = 1'b1;
    while (!rdy0 && n < 1000) begin
      tick();
      n++;
      if (rdy2 && n2 == 0) n2 = n;
      if (n == 255) idlate = id0;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL rst_sweep_len got=%0d exp=256", n);
    end
    checks++;
    if (n2 != 64) begin
      errors++;
      $display("FAIL rst_sweep_len_small got=%0d exp=64", n2);
    end
    checks++;
    if (idlate !== 1'b0) begin
      errors++;
      $display("FAIL rst_done_early got=%b exp=0", idlate);
    end
    checks++;
    if ({id0, id1, id2, rdy1} !== 4'b1111) begin
      errors++;
      $display("FAIL rst_done got=%b exp=1111", {id0, id1, id2, rdy1});
    end
    h0 = '0;
    h1 = '0;
    h2 = '0;
    init_model();
  endtask

  // Three back-to-back reads; u0/u2 answer next cycle, u1 one later.
  task automatic test_reads(input logic [7:0] a0,
                            input logic [7:0] a1,
                            input logic [7:0] a2);
    logic [7:0] ad [3];
    logic [7:0] a;
    logic       e0, e1;
    ad = '{a0, a1, a2};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1, 0, ad[i], 8'h00);
      else       drive(0, 0, 8'h00, 8'h00);
      tick();
      e0 = (i < 3);
      e1 = (i >= 1 && i <= 3);
      if (e0) begin
        a  = ad[i];
        h0 = mem0[a];
        h2 = mem2[a[5:0]];
      end
      if (e1) begin
        a  = ad[i-1];
        h1 = mem0[a];
      end
      checks++;
      if (rv0 !== e0 || rd0 !== h0) begin
        errors++;
        $display("FAIL rd_lat1 i=%0d got=%b/%0h exp=%b/%0h",
                 i, rv0, rd0, e0, h0);
      end
      checks++;
      if (rv1 !== e1 || rd1 !== h1) begin
        errors++;
        $display("FAIL rd_lat2 i=%0d got=%b/%0h exp=%b/%0h",
                 i, rv1, rd1, e1, h1);
      end
      checks++;
      if (rv2 !== e0 || rd2 !== h2) begin
        errors++;
        $display("FAIL rd_small i=%0d got=%b/%0h exp=%b/%0h",
                 i, rv2, rd2, e0, h2);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1, 1, 8'h3C, 8'hA5);
    mem0[8'h3C] = 8'hA5;
    mem2[6'h3C] = 4'h5;
    tick();
    checks++;
    if (rv0 !== 1'b0 || rd0 !== h0 || rv1 !== 1'b0) begin
      errors++;
      $display("FAIL wr_no_rsp got=%b/%0h/%b exp=0/%0h/0",
               rv0, rd0, rv1, h0);
    end
    drive(1, 0, 8'h3C, 8'h00);
    tick();
    h0 = 8'hA5;
    h2 = 4'h5;
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd got=%b/%0h exp=1/a5", rv0, rd0);
    end
    checks++;
    if (rv2 !== 1'b1 || rd2 !== 4'h5) begin
      errors++;
      $display("FAIL wr_rd_small got=%b/%0h exp=1/5", rv2, rd2);
    end
    drive(0, 0, 8'h00, 8'h00);
    tick();
    h1 = 8'hA5;
    checks++;
    if (rv0 !== 1'b0 || rd0 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_hold got=%b/%0h exp=0/a5", rv0, rd0);
    end
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_lat2 got=%b/%0h exp=1/a5", rv1, rd1);
    end
    tick();
    checks++;
    if (rv1 !== 1'b0 || rd1 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_hold_lat2 got=%b/%0h exp=0/a5", rv1, rd1);
    end
  endtask

  task automatic test_random();
    int         due0 [$];
    int         due1 [$];
    int         due2 [$];
    logic [7:0] dq0 [$];
    logic [7:0] dq1 [$];
    logic [3:0] dq2 [$];
    logic       v, we, e;
    logic [7:0] a, d;
    for (int c = 0; c < 402; c++) begin
      v  = (c < 400) && ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      d  = 8'($urandom);
      drive(v, we, a, d);
      if (v && !we) begin
        due0.push_back(cyc + 1);
        due1.push_back(cyc + 2);
        due2.push_back(cyc + 1);
        dq0.push_back(mem0[a]);
        dq1.push_back(mem0[a]);
        dq2.push_back(mem2[a[5:0]]);
      end
      if (v && we) begin
        mem0[a]      = d;
        mem2[a[5:0]] = d[3:0];
      end
      tick();
      e = 1'b0;
      if (due0.size() != 0 && due0[0] == cyc) begin
        e = 1'b1;
        void'(due0.pop_front());
        h0 = dq0.pop_front();
      end
      checks++;
      if (rv0 !== e || rd0 !== h0) begin
        errors++;
        $display("FAIL rnd_lat1 cyc=%0d got=%b/%0h exp=%b/%0h",
                 cyc, rv0, rd0, e, h0);
      end
      e = 1'b0;
      if (due1.size() != 0 && due1[0] == cyc) begin
        e = 1'b1;
        void'(due1.pop_front());
        h1 = dq1.pop_front();
      end
      checks++;
      if (rv1 !== e || rd1 !== h1) begin
        errors++;
        $display("FAIL rnd_lat2 cyc=%0d got=%b/%0h exp=%b/%0h",
                 cyc, rv1, rd1, e, h1);
      end
      e = 1'b0;
      if (due2.size() != 0 && due2[0] == cyc) begin
        e = 1'b1;
        void'(due2.pop_front());
        h2 = dq2.pop_front();
      end
      checks++;
      if (rv2 !== e || rd2 !== h2) begin
        errors++;
        $display("FAIL rnd_small cyc=%0d got=%b/%0h exp=%b/%0h",
                 cyc, rv2, rd2, e, h2);
      end
    end
  endtask

`ifdef PARAM_BRAM_PARITY_EN
  task automatic test_parity();
    drive(1, 0, 8'h13, 8'h00);
    tick();
    h0 = mem0[8'h13];
    h2 = mem2[6'h13];
    checks++;
    if (rv2 !== 1'b1 || rd2 !== h2 || pe2 !== 1'b0 || pe0 !== 1'b0) begin
      errors++;
      $display("FAIL par_clean got=%b/%0h/%b/%b exp=1/%0h/0/0",
               rv2, rd2, pe2, pe0, h2);
    end
    drive(0, 0, 8'h00, 8'h00);
    tick();
    h1 = mem0[8'h13];
    checks++;
    if (rv1 !== 1'b1 || pe1 !== 1'b0) begin
      errors++;
      $display("FAIL par_clean_lat2 got=%b/%b exp=1/0", rv1, pe1);
    end
    u2.u_arr.mem[6'h13] = u2.u_arr.mem[6'h13] ^ 5'h01;
    mem2[6'h13] = mem2[6'h13] ^ 4'h1;
    drive(1, 0, 8'h13, 8'h00);
    tick();
    h0 = mem0[8'h13];
    h2 = mem2[6'h13];
    checks++;
    if (rv2 !== 1'b1 || rd2 !== h2 || pe2 !== 1'b1) begin
      errors++;
      $display("FAIL par_err got=%b/%0h/%b exp=1/%0h/1",
               rv2, rd2, pe2, h2);
    end
    drive(0, 0, 8'h00, 8'h00);
    tick();
    h1 = mem0[8'h13];
    checks++;
    if (pe2 !== 1'b0 || rv2 !== 1'b0) begin
      errors++;
      $display("FAIL par_pulse got=%b/%b exp=0/0", pe2, rv2);
    end
  endtask
`endif

  task automatic test_clear();
    int   n;
    logic seen;
    drive(1, 1, 8'h05, 8'h00);
    mem0[8'h05] = 8'h00;
    mem2[6'h05] = 4'h0;
    tick();
    drive(1, 0, 8'h05, 8'h00);
    tick();
    h0 = 8'h00;
    h2 = 4'h0;
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 8'h00) begin
      errors++;
      $display("FAIL clr_pre_read got=%b/%0h exp=1/0", rv0, rd0);
    end
    drive(0, 0, 8'h00, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (rv1 !== 1'b0 || rd1 !== h1) begin
      errors++;
      $display("FAIL clr_cancel got=%b/%0h exp=0/%0h", rv1, rd1, h1);
    end
    checks++;
    if (rdy0 !== 1'b0 || id0 !== 1'b0) begin
      errors++;
      $display("FAIL clr_state got=%b/%b exp=0/0", rdy0, id0);
    end
    n = 0;
    seen = 1'b0;
    while (!rdy0 && n < 1000) begin
      tick();
      n++;
      if (rv0 || rv1 || rv2) seen = 1'b1;
    end
    checks++;
    if (n != 256 || seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_sweep got=%0d/%b exp=256/0", n, seen);
    end
    init_model();
    test_reads(8'h05, 8'h06, 8'h07);
    drive(1, 0, 8'h05, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(0, 0, 8'h00, 8'h00);
    checks++;
    if (rv0 !== 1'b0 || rd0 !== h0) begin
      errors++;
      $display("FAIL clr_drop got=%b/%0h exp=0/%0h", rv0, rd0, h0);
    end
    n = 0;
    seen = 1'b0;
    while (!rdy0 && n < 1000) begin
      tick();
      n++;
      if (rv0 || rv1 || rv2) seen = 1'b1;
    end
    checks++;
    if (n != 256 || seen !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop_sweep got=%0d/%b exp=256/0", n, seen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1, 1, 8'h00, 8'h33);
    mem0[8'h00] = 8'h33;
    tick();
    drive(0, 0, 8'h00, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({rdy0, rv0, id0, rd0, rd1, rd2} !== 23'd0) begin
      errors++;
      $display("FAIL mid_rst_async got=%0h exp=0",
               {rdy0, rv0, id0, rd0, rd1, rd2});
    end
    h0 = '0;
    h1 = '0;
    h2 = '0;
    tick();
    tick();
    reset = 1'b1;
    wait_ready(n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL mid_rst_sweep got=%0d exp=256", n);
    end
    init_model();
    test_reads(8'h00, 8'h64, 8'hC8);
  endtask

  initial begin
    test_reset();
    test_reads(8'h00, 8'h10, 8'hFF);
    test_reads(8'h01, 8'h02, 8'h03);
    test_reads(8'h13, 8'h3C, 8'h20);
    test_write_read();
    test_random();
`ifdef PARAM_BRAM_PARITY_EN
    test_parity();
`endif
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
